// File: rtl/fetch_queue_if.sv
// Fetch queue bus: instruction-memory request/response side plus decode-side handshake.
// The master modport is the queue itself; slave is the memory/decode environment.
interface fetch_queue_if;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    modport master (
        input  redirect, redirect_pc, mem_gnt, mem_rvalid, mem_rdata, out_ready,
        output mem_req, mem_addr, out_valid, out_instr, out_pc
    );

    modport slave (
        output redirect, redirect_pc, mem_gnt, mem_rvalid, mem_rdata, out_ready,
        input  mem_req, mem_addr, out_valid, out_instr, out_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: credit-limited word fetcher feeding a DEPTH-entry PC/instr FIFO.
// Optional macro FETCH_QUEUE_BYPASS_EN forwards a response straight to decode when the queue is empty.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic          clk,
    input logic          reset,
    fetch_queue_if.master bus
);
    localparam int          PW  = $clog2(DEPTH);
    localparam int          CW  = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] discard_q, discard_d;

    logic [31:0] instr_mem [DEPTH];
    logic [31:0] pc_mem [DEPTH];

    logic [CW:0] credit_sum;
    logic        grant, rsp, drop, accept, push, pop, fifo_valid;
    logic        byp_valid, byp_taken;

    // Credits cover both buffered entries and in-flight fetches, so a push always has room.
    assign credit_sum  = {1'b0, count_q} + {1'b0, outst_q};
    assign bus.mem_req  = !bus.redirect && (credit_sum < (CW+1)'(DEPTH));
    assign bus.mem_addr = fetch_pc_q;

    assign grant      = bus.mem_req && bus.mem_gnt;
    assign rsp        = bus.mem_rvalid && (outst_q != '0);
    assign drop       = rsp && (discard_q != '0);
    assign accept     = rsp && (discard_q == '0);
    assign fifo_valid = (count_q != '0);
    assign pop        = fifo_valid && bus.out_ready;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign byp_valid = accept && !fifo_valid && !bus.redirect;
    assign byp_taken = byp_valid && bus.out_ready;
`else
    assign byp_valid = 1'b0;
    assign byp_taken = 1'b0;
`endif

    assign push = accept && !byp_taken;

    always_comb begin
        bus.out_valid = fifo_valid || byp_valid;
        bus.out_instr = NOP;
        bus.out_pc    = 32'h0;
        if (fifo_valid) begin
            bus.out_instr = instr_mem[rd_ptr_q];
            bus.out_pc    = pc_mem[rd_ptr_q];
        end else if (byp_valid) begin
            bus.out_instr = bus.mem_rdata;
            bus.out_pc    = resp_pc_q;
        end
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        outst_d    = outst_q;
        discard_d  = discard_q;
        if (bus.redirect) begin
            // Every fetch still in flight becomes stale; the one returning now is retired.
            fetch_pc_d = bus.redirect_pc & 32'hFFFF_FFFC;
            resp_pc_d  = bus.redirect_pc & 32'hFFFF_FFFC;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            outst_d    = outst_q - CW'(rsp);
            discard_d  = outst_q - CW'(rsp);
        end else begin
            if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
            outst_d = outst_q + CW'(grant) - CW'(rsp);
            if (drop) discard_d = discard_q - CW'(1);
            if (accept) resp_pc_d = resp_pc_q + 32'd4;
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            outst_q    <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
        end
    end

    // Storage is data only; validity comes entirely from count_q.
    always_ff @(posedge clk) begin
        if (push && !bus.redirect) begin
            instr_mem[wr_ptr_q] <= bus.mem_rdata;
            pc_mem[wr_ptr_q]    <= resp_pc_q;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a latency-configurable in-order memory model.
module tb_fetch_queue;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam int LAT_OUT = 0;
`else
    localparam int LAT_OUT = 1;
`endif
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_queue_if bus ();

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t pq[$];
    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int gcnt   = 0;
    int lat    = 1;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[23:0], 8'h13} ^ 32'h5A00_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    // One clock: record grant/response seen this cycle, then present the next response.
    task automatic step();
        logic req_s, gnt_s, rv_s;
        logic [31:0] addr_s;
        #1;
        req_s  = bus.mem_req;
        gnt_s  = bus.mem_gnt;
        rv_s   = bus.mem_rvalid;
        addr_s = bus.mem_addr;
        @(posedge clk);
        #1;
        if (rv_s) pq.delete(0);
        if (req_s && gnt_s) begin
            pq.push_back('{addr: addr_s, due: cyc + lat});
            gcnt++;
        end
        cyc++;
        if (pq.size() > 0 && pq[0].due <= cyc) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = instr_of(pq[0].addr);
        end else begin
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = 32'h0;
        end
    endtask

    task automatic do_reset(input string tag);
        reset           = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.mem_gnt     = 1'b0;
        bus.mem_rvalid  = 1'b0;
        bus.mem_rdata   = 32'h0;
        bus.out_ready   = 1'b1;
        pq.delete();
        #1;
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_instr"}, bus.out_instr, NOP);
        chk({tag, "_pc"}, bus.out_pc, 32'h0);
        chk({tag, "_req"}, 32'(bus.mem_req), 32'd1);
        chk({tag, "_addr"}, bus.mem_addr, 32'h0);
        @(posedge clk);
        #1;
        reset       = 1'b1;
        cyc         = 0;
        gcnt        = 0;
        bus.mem_gnt = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Streaming with 1-cycle memory latency
        do_reset("rst0");
        lat = 1;
        for (int i = 0; i < 10; i++) begin
            settle();
            chk("stream_valid", 32'(bus.out_valid), (i >= 1 + LAT_OUT) ? 32'd1 : 32'd0);
            if (i >= 1 + LAT_OUT) begin
                chk("stream_pc", bus.out_pc, 32'(4 * (i - 1 - LAT_OUT)));
                chk("stream_instr", bus.out_instr, instr_of(32'(4 * (i - 1 - LAT_OUT))));
            end
            step();
        end

        // Back-pressure: fills exactly DEPTH, then drains in order
        do_reset("rst1");
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) step();
        settle();
        chk("full_grants", 32'(gcnt), 32'd4);
        chk("full_req", 32'(bus.mem_req), 32'd0);
        chk("full_valid", 32'(bus.out_valid), 32'd1);
        chk("full_pc", bus.out_pc, 32'h0);
        bus.out_ready = 1'b1;
        settle();
        chk("drain_req0", 32'(bus.mem_req), 32'd0);
        step();
        settle();
        chk("drain_pc4", bus.out_pc, 32'h4);
        chk("drain_req1", 32'(bus.mem_req), 32'd1);
        chk("drain_addr", bus.mem_addr, 32'h10);
        step();
        settle();
        chk("drain_pc8", bus.out_pc, 32'h8);
        step();
        settle();
        chk("drain_pc12", bus.out_pc, 32'hC);
        step();
        settle();
        chk("drain_pc16", bus.out_pc, 32'h10);
        chk("drain_instr16", bus.out_instr, instr_of(32'h10));

        // Latency 3, two stale fetches in flight at redirect
        do_reset("rst2");
        lat = 3;
        step();
        step();
        bus.mem_gnt     = 1'b0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h100;
        settle();
        chk("redir_req_low", 32'(bus.mem_req), 32'd0);
        step();
        bus.redirect = 1'b0;
        bus.mem_gnt  = 1'b1;
        settle();
        chk("redir_req", 32'(bus.mem_req), 32'd1);
        chk("redir_addr", bus.mem_addr, 32'h100);
        while (cyc < 6 + LAT_OUT) begin
            settle();
            chk("stale_dropped", 32'(bus.out_valid), 32'd0);
            step();
        end
        settle();
        chk("redir_valid", 32'(bus.out_valid), 32'd1);
        chk("redir_pc", bus.out_pc, 32'h100);
        chk("redir_instr", bus.out_instr, instr_of(32'h100));
        step();
        settle();
        chk("redir_pc2", bus.out_pc, 32'h104);

        // Redirect coinciding with a pop and an arriving response; unaligned target
        do_reset("rst3");
        lat = 1;
        step();
        step();
        step();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h203;
        settle();
        chk("coll_req_low", 32'(bus.mem_req), 32'd0);
        step();
        bus.redirect = 1'b0;
        settle();
        chk("coll_addr", bus.mem_addr, 32'h200);
        chk("coll_req", 32'(bus.mem_req), 32'd1);
        chk("coll_empty", 32'(bus.out_valid), 32'd0);
        step();
        for (int k = 0; k <= LAT_OUT; k++) begin
            settle();
            chk("coll_valid", 32'(bus.out_valid), (k == LAT_OUT) ? 32'd1 : 32'd0);
            if (k == LAT_OUT) chk("coll_pc", bus.out_pc, 32'h200);
            step();
        end

        // Fetch address wrap at the top of the address space
        do_reset("rst4");
        step();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        step();
        bus.redirect = 1'b0;
        settle();
        chk("wrap_addr0", bus.mem_addr, 32'hFFFF_FFFC);
        step();
        settle();
        chk("wrap_addr1", bus.mem_addr, 32'h0);
        for (int k = 0; k < LAT_OUT; k++) begin
            chk("wrap_pre_valid", 32'(bus.out_valid), 32'd0);
            step();
            settle();
        end
        chk("wrap_pc0", bus.out_pc, 32'hFFFF_FFFC);
        step();
        settle();
        chk("wrap_pc1", bus.out_pc, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
